// File: rtl/adc_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer_if
// Bundles every signal between the ADC scan sequencer and the rest of the
// system: the scan controls from the toplevel, the frame handshake with the
// SPI master, and the tagged-sample and status outputs.
//
// Signal names carry the direction as seen from the sequencer.
//   i_start        1   level; 1 = scan, 0 = stop after the current frame
//   i_ch_mask      4   channel enable bits; bit n set = channel n scanned
//   i_fin          1   one-cycle frame-end pulse from the SPI master
//   i_data_miso    16  SPI master result, valid with i_fin
//   o_ena          1   SPI master enable, high for exactly one frame
//   o_data_mosi    16  ADC command word for the frame
//   o_sample_data  16  captured result
//   o_sample_ch    2   channel o_sample_data belongs to
//   o_sample_valid 1   one-cycle pulse when a tagged sample is ready
//   o_busy         1   high in every state except IDLE
//   o_overrun_err  1   sticky: a period tick fell while a frame was in flight
//   o_timeout_err  1   sticky: FIN was not seen within TIMEOUT cycles
//
// Modports: master = the sequencer, slave = the SPI master / toplevel side.
// -----------------------------------------------------------------------------
interface adc_scan_sequencer_if;
    logic        i_start;
    logic [3:0]  i_ch_mask;
    logic        i_fin;
    logic [15:0] i_data_miso;
    logic        o_ena;
    logic [15:0] o_data_mosi;
    logic [15:0] o_sample_data;
    logic [1:0]  o_sample_ch;
    logic        o_sample_valid;
    logic        o_busy;
    logic        o_overrun_err;
    logic        o_timeout_err;

    modport master (
        input  i_start, i_ch_mask, i_fin, i_data_miso,
        output o_ena, o_data_mosi, o_sample_data, o_sample_ch,
               o_sample_valid, o_busy, o_overrun_err, o_timeout_err
    );

    modport slave (
        output i_start, i_ch_mask, i_fin, i_data_miso,
        input  o_ena, o_data_mosi, o_sample_data, o_sample_ch,
               o_sample_valid, o_busy, o_overrun_err, o_timeout_err
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
// Launches one SPI ADC frame every PERIOD clocks, cycling round-robin over the
// channels enabled in i_ch_mask. The ADC is pipelined: the result returned at
// the end of a frame belongs to the channel commanded in the previous frame,
// so results are re-tagged with that earlier channel before being emitted.
//
// Ports
//   i_sys_clk  system clock
//   i_rst      synchronous reset, active-high
//   io_bus     adc_scan_sequencer_if.master (controls, SPI handshake, samples,
//              status flags; see the interface file)
//
// Parameters
//   PERIOD      clocks between frame launches (>= 4)
//   GAP_CYCLES  minimum ENA-low clocks after FIN before the next launch (>= 1)
//   TIMEOUT     maximum ENA-high clocks without FIN before the frame aborts
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
    parameter int PERIOD     = 128,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    adc_scan_sequencer_if.master  io_bus
);

    localparam int PCW = $clog2(PERIOD);
    localparam int XCW = $clog2(TIMEOUT + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_XFER, S_GAP} state_t;

    // Single-ended, internal reference, channel in bits [8:7].
    function automatic logic [15:0] cmd_word(input logic [1:0] ch);
        return {4'b0001, 1'b1, 2'b00, ch, 7'b1000000};
    endfunction

    function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    // First set bit strictly after cur, wrapping; offset 4 (== 0 in two bits)
    // lands back on cur, so a single-bit mask repeats its channel. Smaller
    // offsets are evaluated later and win. An empty mask leaves cur unchanged.
    function automatic logic [1:0] next_ch(input logic [3:0] mask,
                                           input logic [1:0] cur);
        logic [1:0] cand;
        logic [1:0] res;
        res = cur;
        for (int off = 4; off >= 1; off--) begin
            cand = cur + 2'(off);
            if (mask[cand]) res = cand;
        end
        return res;
    endfunction

    state_t           r_state;
    logic [PCW-1:0]   r_pcnt;
    logic [XCW-1:0]   r_xcnt;
    logic [GCW-1:0]   r_gcnt;
    logic [1:0]       r_cur_ch;
    logic [1:0]       r_prev_ch;
    logic             r_prev_valid;
    logic             r_ena;
    logic [15:0]      r_data_mosi;
    logic [15:0]      r_sample_data;
    logic [1:0]       r_sample_ch;
    logic             r_sample_valid;
    logic             r_busy;
    logic             r_overrun_err;
    logic             r_timeout_err;

    logic             w_tick;
    logic             w_scan_req;

    assign w_tick     = (r_pcnt == '0);
    assign w_scan_req = io_bus.i_start && (io_bus.i_ch_mask != 4'b0000);

    // NOTE: every register, state included, is cleared inside the clocked
    // block on i_rst, so a reset mid-frame drops ENA on the very next edge.
    // NOTE: sequential state uses non-blocking assignments only, so the order
    // of statements below never changes which value another branch reads.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_pcnt         <= '0;
            r_xcnt         <= '0;
            r_gcnt         <= '0;
            r_cur_ch       <= 2'd0;
            r_prev_ch      <= 2'd0;
            r_prev_valid   <= 1'b0;
            r_ena          <= 1'b0;
            r_data_mosi    <= cmd_word(2'd0);
            r_sample_data  <= '0;
            r_sample_ch    <= 2'd0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun_err  <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;

            // Launch grid runs freely whenever a scan is active.
            if (r_state != S_IDLE)
                r_pcnt <= (r_pcnt == PCW'(PERIOD - 1)) ? '0 : r_pcnt + PCW'(1);

            unique case (r_state)
                S_IDLE: begin
                    if (w_scan_req) begin
                        r_state      <= S_ARM;
                        r_pcnt       <= '0;
                        r_cur_ch     <= lowest_ch(io_bus.i_ch_mask);
                        r_prev_valid <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end

                S_ARM: begin
                    if (!io_bus.i_start) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_state     <= S_XFER;
                        r_ena       <= 1'b1;
                        r_data_mosi <= cmd_word(r_cur_ch);
                        r_xcnt      <= '0;
                    end
                end

                S_XFER: begin
                    // A tick that lands inside a frame is lost; ARM waits
                    // for the following one.
                    if (w_tick) r_overrun_err <= 1'b1;

                    if (io_bus.i_fin) begin
                        if (r_prev_valid) begin
                            r_sample_data  <= io_bus.i_data_miso;
                            r_sample_ch    <= r_prev_ch;
                            r_sample_valid <= 1'b1;
                        end
                        r_prev_ch    <= r_cur_ch;
                        r_prev_valid <= 1'b1;
                        r_cur_ch     <= next_ch(io_bus.i_ch_mask, r_cur_ch);
                        r_ena        <= 1'b0;
                        r_gcnt       <= '0;
                        r_state      <= S_GAP;
                    end else if (r_xcnt == XCW'(TIMEOUT - 1)) begin
                        // Pipeline content is unknown after an abort, so the
                        // next result must not be tagged; channel is retried.
                        r_timeout_err <= 1'b1;
                        r_prev_valid  <= 1'b0;
                        r_ena         <= 1'b0;
                        r_gcnt        <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_xcnt <= r_xcnt + XCW'(1);
                    end
                end

                S_GAP: begin
                    if (w_tick) r_overrun_err <= 1'b1;

                    if (r_gcnt == GCW'(GAP_CYCLES - 1)) begin
                        if (w_scan_req) begin
                            r_state <= S_ARM;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gcnt <= r_gcnt + GCW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.o_ena          = r_ena;
    assign io_bus.o_data_mosi    = r_data_mosi;
    assign io_bus.o_sample_data  = r_sample_data;
    assign io_bus.o_sample_ch    = r_sample_ch;
    assign io_bus.o_sample_valid = r_sample_valid;
    assign io_bus.o_busy         = r_busy;
    assign io_bus.o_overrun_err  = r_overrun_err;
    assign io_bus.o_timeout_err  = r_timeout_err;

endmodule
